// File: rtl/design_gen_pkg.sv
// design_gen_pkg: shared types and helpers for the design_gen MAC block.
//   op_t        - operation selected by the OP parameter (multiply / add)
//   eng_state_t - engine FSM states
//   clog2       - elaboration-time ceiling log2, used to size counters/pointers
package design_gen_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_ADD = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WAIT = 2'd2
    } eng_state_t;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/design_gen_fifo.sv
// design_gen_fifo: synchronous operand-pair queue, DEPTH entries of 2*WIDTH bits.
//   CLK          - clock
//   RST          - synchronous active-high reset (clears count and pointers)
//   enq_i        - write enq_data_i at the rising edge (caller gates with !full_o)
//   enq_data_i   - {a, b}
//   deq_i        - drop the head entry at the rising edge (caller gates with !empty_o)
//   deq_data_o   - head entry, valid while empty_o = 0
//   full_o       - no free entry
//   empty_o      - no stored entry
module design_gen_fifo
    import design_gen_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 enq_i,
    input  logic [2*WIDTH-1:0]   enq_data_i,
    input  logic                 deq_i,
    output logic [2*WIDTH-1:0]   deq_data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PW = clog2(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW:0]        count_q,  count_d;

    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign deq_data_o = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (deq_i) rd_ptr_d = rd_ptr_q + PW'(1);
        if (enq_i && !deq_i)      count_d = count_q + (PW+1)'(1);
        else if (!enq_i && deq_i) count_d = count_q - (PW+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers and count
    // already makes every entry unreachable, and an unreset array maps to RAM.
    always_ff @(posedge CLK) begin
        if (enq_i) mem[wr_ptr_q] <= enq_data_i;
    end

endmodule

// File: rtl/design_gen_mac.sv
// design_gen_mac: queued operand pairs -> sequential multiply/add engine ->
// one-entry result register -> running modular checksum on consume.
//   CLK, RST              - clock, synchronous active-high reset
//   start_a, start_b      - operands; EN_start enqueues them when RDY_start = 1
//   RDY_start             - input queue not full
//   resresult, RDY_result - result register value (0 when empty) and its valid
//   EN_check              - consume strobe, honoured when RDY_check = 1
//   chresult              - checksum + resresult, combinational
//   RDY_check             - same as RDY_result
module design_gen_mac
    import design_gen_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    parameter int OP    = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] start_a,
    input  logic [WIDTH-1:0] start_b,
    input  logic             EN_start,
    output logic             RDY_start,
    output logic [WIDTH-1:0] resresult,
    output logic             RDY_result,
    input  logic             EN_check,
    output logic [WIDTH-1:0] chresult,
    output logic             RDY_check
);

    localparam op_t OP_SEL = (OP == 0) ? OP_MUL : OP_ADD;
    localparam int  CW     = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    eng_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ma_q, ma_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] csum_q, csum_d;

    logic                fifo_full, fifo_empty, enq, pop;
    logic [2*WIDTH-1:0]  head;
    logic                consume, out_free, last;

    assign enq = EN_start && !fifo_full;

    design_gen_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .enq_i      (enq),
        .enq_data_i ({start_a, start_b}),
        .deq_i      (pop),
        .deq_data_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign RDY_start  = !fifo_full;
    assign RDY_result = out_valid_q;
    assign RDY_check  = out_valid_q;
    assign resresult  = out_valid_q ? out_q : '0;
    assign chresult   = csum_q + resresult;

    assign consume  = EN_check && out_valid_q;
    // The result slot can take a new value if empty or being emptied this edge.
    assign out_free = !out_valid_q || consume;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        csum_d      = csum_q;
        pop         = 1'b0;
        last        = 1'b0;

        if (consume) begin
            csum_d      = chresult;
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    acc_d   = '0;
                    ma_d    = head[2*WIDTH-1:WIDTH];
                    mb_d    = head[WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (OP_SEL == OP_MUL) begin
                    acc_d = mb_q[0] ? (acc_q + ma_q) : acc_q;
                    ma_d  = ma_q << 1;
                    mb_d  = mb_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    last  = (cnt_q == CW'(WIDTH - 1));
                end else begin
                    acc_d = ma_q + mb_q;
                    last  = 1'b1;
                end
                if (last) begin
                    if (out_free) begin
                        out_d       = acc_d;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (out_free) begin
                    out_d       = acc_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            csum_q      <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            csum_q      <= csum_d;
        end
    end

endmodule

// File: tb/tb_design_gen_mac.sv
// tb_design_gen_mac: directed bench for design_gen_mac with two instances,
// index 0 = multiply (OP=0), index 1 = add (OP=1), WIDTH=12, DEPTH=4.
module tb_design_gen_mac;

    localparam int W = 12;

    logic         clk;
    logic         rst   [2];
    logic [W-1:0] sa    [2];
    logic [W-1:0] sb    [2];
    logic         en_s  [2];
    logic         en_c  [2];
    logic         rdy_s [2];
    logic [W-1:0] res   [2];
    logic         rdy_r [2];
    logic [W-1:0] chres [2];
    logic         rdy_c [2];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    design_gen_mac #(.WIDTH(W), .DEPTH(4), .OP(0)) u_mul (
        .CLK(clk), .RST(rst[0]), .start_a(sa[0]), .start_b(sb[0]),
        .EN_start(en_s[0]), .RDY_start(rdy_s[0]), .resresult(res[0]),
        .RDY_result(rdy_r[0]), .EN_check(en_c[0]), .chresult(chres[0]),
        .RDY_check(rdy_c[0])
    );

    design_gen_mac #(.WIDTH(W), .DEPTH(4), .OP(1)) u_add (
        .CLK(clk), .RST(rst[1]), .start_a(sa[1]), .start_b(sb[1]),
        .EN_start(en_s[1]), .RDY_start(rdy_s[1]), .resresult(res[1]),
        .RDY_result(rdy_r[1]), .EN_check(en_c[1]), .chresult(chres[1]),
        .RDY_check(rdy_c[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int u);
        rst[u] = 1'b1;
        tick();
        rst[u] = 1'b0;
    endtask

    task automatic start(input int u, input logic [W-1:0] a, input logic [W-1:0] b);
        check("start_rdy", {31'd0, rdy_s[u]}, 32'd1);
        sa[u]   = a;
        sb[u]   = b;
        en_s[u] = 1'b1;
        tick();
        en_s[u] = 1'b0;
    endtask

    // Edges counted from the last start edge; exp_lat = 0 only requires arrival.
    task automatic wait_result(input int u, input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!rdy_r[u] && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_arrived"}, {31'd0, rdy_r[u]}, 32'd1);
        if (exp_lat != 0) check({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic consume(input int u, input string tag, input logic [W-1:0] exp_ch);
        check({tag, "_rdy_check"}, {31'd0, rdy_c[u]}, 32'd1);
        en_c[u] = 1'b1;
        #1;
        check({tag, "_chresult"}, {20'd0, chres[u]}, {20'd0, exp_ch});
        tick();
        en_c[u] = 1'b0;
    endtask

    initial begin
        int acc;
        int n;
        int sum;
        logic was_rdy;
        logic dropped;

        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; sa[u] = '0; sb[u] = '0; en_s[u] = 1'b0; en_c[u] = 1'b0;
        end
        tick();
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset state of both instances
        for (int u = 0; u < 2; u++) begin
            check("rst_rdy_start",  {31'd0, rdy_s[u]}, 32'd1);
            check("rst_rdy_result", {31'd0, rdy_r[u]}, 32'd0);
            check("rst_rdy_check",  {31'd0, rdy_c[u]}, 32'd0);
            check("rst_resresult",  {20'd0, res[u]},   32'd0);
            check("rst_chresult",   {20'd0, chres[u]}, 32'd0);
        end

        // Multiply 3*5, latency WIDTH+1, then consume
        start(0, 12'd3, 12'd5);
        wait_result(0, "mul35", W + 1);
        check("mul35_res", {20'd0, res[0]}, 32'h00F);
        consume(0, "mul35", 12'h00F);
        check("mul35_drop",     {31'd0, rdy_r[0]}, 32'd0);
        check("mul35_res_zero", {20'd0, res[0]},   32'd0);
        check("mul35_csum",     {20'd0, chres[0]}, 32'h00F);

        // Wrap-around products with a cleared checksum
        do_reset(0);
        start(0, 12'hFFF, 12'hFFF);
        wait_result(0, "mulff", W + 1);
        check("mulff_res", {20'd0, res[0]}, 32'h001);
        consume(0, "mulff", 12'h001);
        start(0, 12'h040, 12'h040);
        wait_result(0, "mul40", W + 1);
        check("mul40_res", {20'd0, res[0]}, 32'h000);
        consume(0, "mul40", 12'h001);

        // Capacity: EN_start every cycle, EN_check low
        do_reset(0);
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            sa[0]   = W'(acc + 1);
            sb[0]   = 12'd3;
            en_s[0] = 1'b1;
            was_rdy = rdy_s[0];
            tick();
            if (was_rdy) acc++;
        end
        en_s[0] = 1'b0;
        check("cap_accepted",  acc, 32'd6);
        check("cap_rdy_start", {31'd0, rdy_s[0]}, 32'd0);
        wait_result(0, "cap1", 0);
        check("cap1_res", {20'd0, res[0]}, 32'd3);
        consume(0, "cap1", 12'd3);
        n = 0;
        while (!rdy_s[0] && n < W + 2) begin
            tick();
            n++;
        end
        check("cap_rdy_start_back", {31'd0, rdy_s[0]}, 32'd1);
        sum = 3;
        for (int k = 2; k <= 6; k++) begin
            wait_result(0, "capk", 0);
            check("capk_res", {20'd0, res[0]}, 3 * k);
            sum += 3 * k;
            consume(0, "capk", W'(sum));
        end

        // Reset mid-multiply with two pairs still queued (checksum is 0x03F here)
        start(0, 12'd5, 12'd7);
        start(0, 12'd6, 12'd7);
        start(0, 12'd7, 12'd7);
        repeat (4) tick();
        do_reset(0);
        check("abort_rdy_start",  {31'd0, rdy_s[0]}, 32'd1);
        check("abort_rdy_result", {31'd0, rdy_r[0]}, 32'd0);
        check("abort_chresult",   {20'd0, chres[0]}, 32'd0);
        dropped = 1'b0;
        repeat (40) begin
            tick();
            if (rdy_r[0]) dropped = 1'b1;
        end
        check("abort_no_result", {31'd0, dropped}, 32'd0);

        // Consume in the same cycle the engine finishes the next result
        start(0, 12'd2, 12'd3);
        start(0, 12'd4, 12'd5);
        wait_result(0, "same1", W);
        check("same1_res", {20'd0, res[0]}, 32'd6);
        dropped = 1'b0;
        repeat (W) begin
            tick();
            if (!rdy_r[0]) dropped = 1'b1;
        end
        check("same_hold", {20'd0, res[0]}, 32'd6);
        consume(0, "same1", 12'd6);
        if (!rdy_r[0]) dropped = 1'b1;
        check("same_never_drop", {31'd0, dropped}, 32'd0);
        check("same2_res", {20'd0, res[0]}, 32'h014);
        consume(0, "same2", 12'h01A);
        check("same2_drop", {31'd0, rdy_r[0]}, 32'd0);

        // Add instance: wrap and carry into MSB, latency 2
        start(1, 12'hFFF, 12'h001);
        wait_result(1, "addff", 2);
        check("addff_res", {20'd0, res[1]}, 32'h000);
        consume(1, "addff", 12'h000);
        start(1, 12'h7FF, 12'h001);
        wait_result(1, "add7ff", 2);
        check("add7ff_res", {20'd0, res[1]}, 32'h800);
        consume(1, "add7ff", 12'h800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/design_gen_mac.md
Name: design_gen_mac

Overview:
- Parametrised successor of the fixed 12-bit start/result/check design block.
- start(a,b) enqueues an operand pair into a DEPTH-entry input queue.
- A sequential engine computes one operation per pair (iterative shift-add multiply or single-cycle add) into a one-entry output register.
- result peeks at that register; check consumes it and returns a running modular checksum. The block is a leaf datapath under method-style handshake ports and is used by port-renaming and result regression benches.

Parameters:
- WIDTH, 12, operand/result/checksum width in bits (>=2).
- DEPTH, 4, input queue entries (power of two, >=2).
- OP, 0, 0 = multiply (low WIDTH bits of a*b); 1 = add (a+b mod 2^WIDTH).

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  reset; synchronous, active-high.
- start_a  input  WIDTH  operand a of start.
- start_b  input  WIDTH  operand b of start.
- EN_start  input  1  enqueue strobe; honoured only when RDY_start=1.
- RDY_start  output  1  queue not full.
- resresult  output  WIDTH  output register value; 0 when not valid.
- RDY_result  output  1  output register valid.
- EN_check  input  1  consume strobe; honoured only when RDY_check=1.
- chresult  output  WIDTH  checksum + output register, combinational, same cycle as EN_check.
- RDY_check  output  1  equals RDY_result.

Behaviour:
- Reset (RST high at an edge) clears the following: queue count and pointers, engine state (IDLE), output valid, checksum (0), and all datapath registers.
- After reset: RDY_start=1, RDY_result=RDY_check=0, resresult=chresult=0.
- EN_start and EN_check are ignored while RST is high.
- EN_start while RDY_start=0, or EN_check while RDY_check=0, has no effect.
- Queue:
  - Enqueue on EN_start&&!full; pointers wrap modulo DEPTH.
  - No bypass: an entry enqueued at edge E is poppable from E+1.
  - Simultaneous enqueue and pop is legal and leaves the count unchanged.
- Engine FSM, states IDLE, BUSY, WAIT:
  - IDLE: if the queue is non-empty, pop the head, load acc=0, ma=a, mb=b, cnt=0, and go to BUSY. Otherwise stay in IDLE.
  - BUSY, OP=0: each cycle, if mb[0] then acc+=ma (mod 2^WIDTH); ma<<=1; mb>>=1; cnt++. At the last cycle (cnt==WIDTH-1) the result is final.
  - BUSY, OP=1: one cycle computes acc=ma+mb; that cycle is the last.
  - At the last BUSY cycle: if the output register is empty, or is being consumed by EN_check that cycle, write acc to it (valid=1) and go to IDLE. Otherwise go to WAIT holding acc.
  - WAIT: write under the same condition as above, then go to IDLE.
  - IDLE never pops in the same cycle it writes; the pop occurs the following cycle.
- Latency: an EN_start accepted at edge E0 into an empty, idle block gives RDY_result=1 after edge E0+WIDTH+1 (OP=0) or E0+2 (OP=1).
- Throughput: OP=0 completes one result per WIDTH+1 cycles.
- check: on EN_check, chresult = (checksum + resresult) mod 2^WIDTH. The checksum register takes that value and valid clears at the edge, unless the engine writes a new result at the same edge, in which case valid stays 1 with the new value.
- Capacity: with check idle, DEPTH+2 starts are accepted (queue, engine, output) before RDY_start stays 0.
- Reset mid-operation aborts BUSY/WAIT and discards queue contents; no partial result appears.

Decomposition:
- Package design_gen_pkg:
  - op_t enum {OP_MUL, OP_ADD}.
  - eng_state_t enum {IDLE, BUSY, WAIT}.
  - Count-width helper function clog2.
- Natural sub-module design_gen_fifo, parameters WIDTH and DEPTH: a 2*WIDTH-wide synchronous FIFO with enq/deq/full/empty and active-high synchronous reset, storing {a,b}.

Test Plan:
- WIDTH=12, OP=0: start(3,5) after reset -> RDY_result rises 13 cycles later, resresult=0x00F. check -> chresult=0x00F, RDY_result falls next cycle.
- OP=0: start(0xFFF,0xFFF) -> resresult=0x001. Then start(0x040,0x040) -> resresult=0x000. Checks return chresult 0x001 then 0x001 (checksum wrap-neutral).
- OP=0, DEPTH=4, EN_check held low, EN_start every cycle -> exactly 6 accepted, then RDY_start=0. One check -> RDY_start returns to 1 within WIDTH+2 cycles. The remaining five results arrive in enqueue order.
- OP=1: start(0xFFF,0x001) -> resresult=0x000 2 cycles later. start(0x7FF,0x001) -> 0x800. Checks give chresult 0x000 then 0x800.
- Reset pulse for one cycle at cnt=5 of a multiply with 2 queued pairs -> next cycle RDY_start=1, RDY_result=0, checksum 0. No result is ever produced for the aborted pairs.
- EN_check asserted in the same cycle the engine finishes a result -> old value consumed, new value valid next cycle, RDY_result never drops.
